pattern_sequencer: RTL and testbench

Parametrised, writable pattern store and frame sequencer for the LED cube. It holds `NUM_PAT` frames of `ROWS`×`COLS` bits, loaded at run time through a row write port. It presents one frame at a time on a double-buffered, tear-free output, which updates only after a full row-by-row copy. Frames are selected manually or advanced automatically with a programmable dwell. It sits between the pattern loader/controller and the layer/row driver.

---
 rtl/pattern_sequencer_pkg.sv | 23 ++
 rtl/pattern_sequencer_if.sv | 44 ++++
 rtl/pattern_sequencer_mem.sv | 43 ++++
 rtl/pattern_sequencer.sv | 117 +++++++++++
 tb/tb_pattern_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pattern_sequencer_pkg.sv
// Shared types, default geometry and the auto-advance wrap rule for the LED cube
// pattern sequencer.
package led_cube_pkg;

    localparam int ROWS_DEF    = 10;
    localparam int COLS_DEF    = 10;
    localparam int NUM_PAT_DEF = 16;
    localparam int HOLD_W_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COPY   = 2'd1,
        COMMIT = 2'd2
    } seq_state_t;

    // Successor in the auto cycle; last_pat is clamped to the top stored pattern.
    function automatic int next_pat(int cur, int last_pat, int num_pat);
        int eff_last;
        eff_last = (last_pat < num_pat - 1) ? last_pat : num_pat - 1;
        return (cur >= eff_last) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/pattern_sequencer_if.sv
// Bundle between the pattern loader/controller (master) and the sequencer (slave),
// including the frame output towards the row driver and a state debug tap.
interface pattern_sequencer_if #(
    parameter int ROWS    = led_cube_pkg::ROWS_DEF,
    parameter int COLS    = led_cube_pkg::COLS_DEF,
    parameter int NUM_PAT = led_cube_pkg::NUM_PAT_DEF,
    parameter int HOLD_W  = led_cube_pkg::HOLD_W_DEF
);
    import led_cube_pkg::*;

    localparam int PW = $clog2(NUM_PAT);
    localparam int RW = $clog2(ROWS);

    // wr_en and sel_load are valid-only strobes with no ready: a row write is taken
    // on every cycle it is valid; sel_load is taken only when busy=0, otherwise it is
    // dropped (busy is the inverted ready), and it is never queued.
    logic                   wr_en;
    logic [PW-1:0]          wr_pat;
    logic [RW-1:0]          wr_row;
    logic [COLS-1:0]        wr_data;
    logic                   sel_load;
    logic [PW-1:0]          sel_pat;
    logic                   auto_en;
    logic [HOLD_W-1:0]      hold_cycles;
    logic [PW-1:0]          last_pat;
    logic [ROWS*COLS-1:0]   frame;
    logic [PW-1:0]          frame_pat;
    logic                   frame_strobe;
    logic                   busy;
    seq_state_t             dbg_state;

    modport master (
        output wr_en, wr_pat, wr_row, wr_data, sel_load, sel_pat,
               auto_en, hold_cycles, last_pat,
        input  frame, frame_pat, frame_strobe, busy, dbg_state
    );

    modport slave (
        input  wr_en, wr_pat, wr_row, wr_data, sel_load, sel_pat,
               auto_en, hold_cycles, last_pat,
        output frame, frame_pat, frame_strobe, busy, dbg_state
    );

endinterface

// File: rtl/pattern_sequencer_mem.sv
// Pattern store: NUM_PAT x ROWS flop array, one row write port and one asynchronous
// row read port that returns the pre-write value on a same-cycle collision.
module pattern_mem #(
    parameter int ROWS    = led_cube_pkg::ROWS_DEF,
    parameter int COLS    = led_cube_pkg::COLS_DEF,
    parameter int NUM_PAT = led_cube_pkg::NUM_PAT_DEF,
    localparam int PW     = $clog2(NUM_PAT),
    localparam int RW     = $clog2(ROWS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_en,
    input  logic [PW-1:0]   wr_pat,
    input  logic [RW-1:0]   wr_row,
    input  logic [COLS-1:0] wr_data,
    input  logic [PW-1:0]   rd_pat,
    input  logic [RW-1:0]   rd_row,
    output logic [COLS-1:0] rd_data
);

    localparam logic [PW:0] PAT_LIM = (PW + 1)'(NUM_PAT);
    localparam logic [RW:0] ROW_LIM = (RW + 1)'(ROWS);

    logic [COLS-1:0] r_mem [NUM_PAT][ROWS];
    logic            w_wr_ok;

    assign w_wr_ok = wr_en && ({1'b0, wr_pat} < PAT_LIM) && ({1'b0, wr_row} < ROW_LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < NUM_PAT; p++) begin
                for (int r = 0; r < ROWS; r++) begin
                    r_mem[p][r] <= '0;
                end
            end
        end else if (w_wr_ok) begin
            r_mem[wr_pat][wr_row] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_pat][rd_row];

endmodule

// File: rtl/pattern_sequencer.sv
// Frame sequencer: copies the selected pattern row by row into a back buffer, then
// commits it to the displayed frame in one edge so the output never tears.
module pattern_sequencer
    import led_cube_pkg::*;
#(
    parameter int ROWS    = ROWS_DEF,
    parameter int COLS    = COLS_DEF,
    parameter int NUM_PAT = NUM_PAT_DEF,
    parameter int HOLD_W  = HOLD_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    pattern_sequencer_if.slave bus
);

    localparam int PW = $clog2(NUM_PAT);
    localparam int RW = $clog2(ROWS);
    localparam logic [PW:0]   PAT_LIM  = (PW + 1)'(NUM_PAT);
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

    seq_state_t           r_state;
    logic [RW-1:0]        r_row;
    logic [HOLD_W-1:0]    r_hold;
    logic [PW-1:0]        r_cur;
    logic [PW-1:0]        r_target;
    logic [PW-1:0]        r_frame_pat;
    logic [COLS-1:0]      r_back [ROWS];
    logic [ROWS*COLS-1:0] r_frame;
    logic                 r_strobe;
    logic                 r_busy;

    logic [COLS-1:0]      w_rd_data;
    logic                 w_sel_ok;
    logic                 w_start;
    logic [PW-1:0]        w_next;
    logic [PW-1:0]        w_start_pat;

    pattern_mem #(
        .ROWS    (ROWS),
        .COLS    (COLS),
        .NUM_PAT (NUM_PAT)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (bus.wr_en),
        .wr_pat  (bus.wr_pat),
        .wr_row  (bus.wr_row),
        .wr_data (bus.wr_data),
        .rd_pat  (r_target),
        .rd_row  (r_row),
        .rd_data (w_rd_data)
    );

    // Manual selection outranks an auto expiry arriving on the same edge.
    assign w_sel_ok    = bus.sel_load && ({1'b0, bus.sel_pat} < PAT_LIM);
    assign w_next      = PW'(next_pat(int'(r_cur), int'(bus.last_pat), NUM_PAT));
    assign w_start     = w_sel_ok || (bus.auto_en && (r_hold == '0));
    assign w_start_pat = w_sel_ok ? bus.sel_pat : w_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_row       <= '0;
            r_hold      <= '0;
            r_cur       <= '0;
            r_target    <= '0;
            r_frame_pat <= '0;
            r_frame     <= '0;
            r_strobe    <= 1'b0;
            r_busy      <= 1'b0;
            for (int r = 0; r < ROWS; r++) begin
                r_back[r] <= '0;
            end
        end else begin
            r_strobe <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_target <= w_start_pat;
                        r_row    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= COPY;
                    end else if (bus.auto_en) begin
                        r_hold <= r_hold - HOLD_W'(1);
                    end
                end
                COPY: begin
                    r_back[r_row] <= w_rd_data;
                    if (r_row == LAST_ROW) begin
                        r_state <= COMMIT;
                    end else begin
                        r_row <= r_row + RW'(1);
                    end
                end
                COMMIT: begin
                    for (int r = 0; r < ROWS; r++) begin
                        r_frame[r*COLS +: COLS] <= r_back[r];
                    end
                    r_frame_pat <= r_target;
                    r_cur       <= r_target;
                    r_hold      <= bus.hold_cycles;
                    r_strobe    <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.frame        = r_frame;
    assign bus.frame_pat    = r_frame_pat;
    assign bus.frame_strobe = r_strobe;
    assign bus.busy         = r_busy;
    assign bus.dbg_state    = r_state;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Bench for pattern_sequencer: a table of manual selections, hand-built collision,
// priority and reset sequences, then random traffic against a timeline model.
module tb_pattern_sequencer;
    import led_cube_pkg::*;

    localparam int ROWS    = 10;
    localparam int COLS    = 10;
    localparam int NUM_PAT = 12;
    localparam int HOLD_W  = 16;
    localparam int PW      = $clog2(NUM_PAT);
    localparam int RW      = $clog2(ROWS);
    localparam int FW      = ROWS * COLS;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pattern_sequencer_if #(.ROWS(ROWS), .COLS(COLS), .NUM_PAT(NUM_PAT), .HOLD_W(HOLD_W)) bus ();

    pattern_sequencer #(.ROWS(ROWS), .COLS(COLS), .NUM_PAT(NUM_PAT), .HOLD_W(HOLD_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a frame is a snapshot of row k taken k+1 edges after the
    // accepting edge, published ROWS+1 edges after it.
    logic [COLS-1:0] m_mem [NUM_PAT][ROWS];
    logic [COLS-1:0] m_snap [ROWS];
    logic [FW-1:0]   m_frame;
    int              m_pat, m_cur, m_dwell, m_tgt, m_e0, cyc;
    bit              m_active, m_strobe;

    typedef struct {
        int sel_pat;
        bit accept;
        int exp_pat;
    } vec_t;
    vec_t vecs [6];

    logic [PW-1:0] exp_q [$];
    logic [PW-1:0] got_q [$];
    int            st_cyc [$];

    task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [COLS-1:0] pat_row(int p, int r);
        logic [COLS-1:0] ones;
        ones = '1;
        if (p == 3) return ones >> r;
        return COLS'((p * 37 + r * 11 + 1) & 32'h3FF);
    endfunction

    function automatic logic [FW-1:0] pat_frame(int p);
        logic [FW-1:0] f;
        for (int r = 0; r < ROWS; r++) f[r*COLS +: COLS] = pat_row(p, r);
        return f;
    endfunction

    function automatic int ref_next(int cur, int last);
        int eff;
        eff = (last < NUM_PAT - 1) ? last : NUM_PAT - 1;
        return (cur >= eff) ? 0 : cur + 1;
    endfunction

    task automatic model_reset();
        for (int p = 0; p < NUM_PAT; p++)
            for (int r = 0; r < ROWS; r++) m_mem[p][r] = '0;
        for (int r = 0; r < ROWS; r++) m_snap[r] = '0;
        m_frame = '0; m_pat = 0; m_cur = 0; m_dwell = 0; m_tgt = 0; m_e0 = 0;
        m_active = 1'b0; m_strobe = 1'b0;
    endtask

    task automatic model_edge();
        int k;
        m_strobe = 1'b0;
        if (m_active) begin
            k = cyc - m_e0;
            if (k >= 1 && k <= ROWS) m_snap[k-1] = m_mem[m_tgt][k-1];
            if (k == ROWS + 1) begin
                for (int r = 0; r < ROWS; r++) m_frame[r*COLS +: COLS] = m_snap[r];
                m_pat = m_tgt; m_cur = m_tgt; m_dwell = int'(bus.hold_cycles);
                m_strobe = 1'b1; m_active = 1'b0;
            end
        end else if (bus.sel_load && int'(bus.sel_pat) < NUM_PAT) begin
            m_active = 1'b1; m_e0 = cyc; m_tgt = int'(bus.sel_pat);
        end else if (bus.auto_en) begin
            if (m_dwell == 0) begin
                m_active = 1'b1; m_e0 = cyc; m_tgt = ref_next(m_cur, int'(bus.last_pat));
            end else begin
                m_dwell--;
            end
        end
        if (bus.wr_en && int'(bus.wr_pat) < NUM_PAT && int'(bus.wr_row) < ROWS)
            m_mem[bus.wr_pat][bus.wr_row] = bus.wr_data;
        cyc++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("frame", bus.frame, m_frame);
        check("frame_pat", FW'(bus.frame_pat), FW'(m_pat));
        check("frame_strobe", FW'(bus.frame_strobe), FW'(m_strobe));
        check("busy", FW'(bus.busy), FW'(m_active));
    endtask

    task automatic write_row(input int p, input int r, input logic [COLS-1:0] d);
        bus.wr_en = 1'b1; bus.wr_pat = PW'(p); bus.wr_row = RW'(r); bus.wr_data = d;
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic pulse_sel(input int p);
        bus.sel_pat = PW'(p); bus.sel_load = 1'b1;
        tick();
        bus.sel_load = 1'b0;
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_frame", bus.frame, '0);
        check("rst_frame_pat", FW'(bus.frame_pat), '0);
        check("rst_strobe", FW'(bus.frame_strobe), '0);
        check("rst_busy", FW'(bus.busy), '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [FW-1:0] shown, want, mod;
        int strobes;
        bit acc;

        vecs[0] = '{3, 1'b1, 3};
        vecs[1] = '{15, 1'b0, 3};
        vecs[2] = '{0, 1'b1, 0};
        vecs[3] = '{11, 1'b1, 11};
        vecs[4] = '{12, 1'b0, 11};
        vecs[5] = '{7, 1'b1, 7};

        bus.wr_en = 1'b0; bus.wr_pat = '0; bus.wr_row = '0; bus.wr_data = '0;
        bus.sel_load = 1'b0; bus.sel_pat = '0; bus.auto_en = 1'b0;
        bus.hold_cycles = '0; bus.last_pat = '0;
        cyc = 0;
        model_reset();

        // Clock/reset
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_frame", bus.frame, '0);
        check("reset_busy", FW'(bus.busy), '0);
        check("reset_state", FW'(bus.dbg_state), FW'(IDLE));

        strobes = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            strobes += int'(bus.frame_strobe);
        end
        check("idle_no_strobe", FW'(strobes), '0);

        for (int p = 0; p < NUM_PAT; p++)
            for (int r = 0; r < ROWS; r++) write_row(p, r, pat_row(p, r));
        write_row(12, 0, '1);
        write_row(5, 10, '1);

        // Table: manual selections, including out-of-range ones that must be ignored
        shown = '0;
        for (int i = 0; i < 6; i++) begin
            acc  = vecs[i].accept;
            want = acc ? pat_frame(vecs[i].exp_pat) : shown;
            pulse_sel(vecs[i].sel_pat);
            check("tbl_busy_start", FW'(bus.busy), FW'(acc));
            for (int k = 1; k <= ROWS + 1; k++) begin
                tick();
                check("tbl_strobe", FW'(bus.frame_strobe), FW'(acc && k == ROWS + 1));
                check("tbl_frame", bus.frame, (k == ROWS + 1) ? want : shown);
                check("tbl_busy", FW'(bus.busy), FW'(acc && k <= ROWS));
            end
            check("tbl_frame_pat", FW'(bus.frame_pat), FW'(vecs[i].exp_pat));
            shown = want;
            tick();
        end

        // Write/copy collisions on pattern 3: row 0 after it was copied, row 9 as it is read
        pulse_sel(3);
        tick();
        bus.wr_en = 1'b1; bus.wr_pat = PW'(3); bus.wr_row = RW'(0); bus.wr_data = 10'h155;
        tick();
        bus.wr_en = 1'b0;
        repeat (7) tick();
        bus.wr_en = 1'b1; bus.wr_pat = PW'(3); bus.wr_row = RW'(9); bus.wr_data = 10'h155;
        tick();
        bus.wr_en = 1'b0;
        tick();
        check("coll_strobe", FW'(bus.frame_strobe), FW'(1));
        check("coll_old_frame", bus.frame, pat_frame(3));
        tick();
        mod = pat_frame(3);
        mod[0 +: COLS] = 10'h155;
        mod[9*COLS +: COLS] = 10'h155;
        pulse_sel(3);
        repeat (ROWS + 1) tick();
        check("coll_reload_frame", bus.frame, mod);

        // Request while busy is dropped; manual select beats a coincident auto expiry
        bus.hold_cycles = HOLD_W'(3);
        pulse_sel(5);
        repeat (3) tick();
        pulse_sel(7);
        repeat (7) tick();
        check("busy_drop_pat", FW'(bus.frame_pat), FW'(5));
        check("busy_drop_frame", bus.frame, pat_frame(5));
        strobes = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            strobes += int'(bus.frame_strobe);
        end
        check("busy_drop_no_second", FW'(strobes), '0);
        bus.auto_en = 1'b1;
        repeat (3) tick();
        check("dwell_not_expired", FW'(bus.busy), '0);
        bus.sel_pat = PW'(8); bus.sel_load = 1'b1;
        tick();
        bus.sel_load = 1'b0; bus.auto_en = 1'b0;
        repeat (ROWS + 1) tick();
        check("coincide_pat", FW'(bus.frame_pat), FW'(8));
        check("coincide_frame", bus.frame, pat_frame(8));

        // Reset in the middle of a copy
        pulse_sel(1);
        repeat (5) tick();
        do_reset();
        strobes = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            strobes += int'(bus.frame_strobe);
        end
        check("post_reset_no_strobe", FW'(strobes), '0);

        // Auto advance from reset: 1,2,0,1 with hold 4
        for (int p = 0; p < 3; p++)
            for (int r = 0; r < ROWS; r++) write_row(p, r, pat_row(p, r));
        bus.hold_cycles = HOLD_W'(4); bus.last_pat = PW'(2); bus.auto_en = 1'b1;
        exp_q = '{PW'(1), PW'(2), PW'(0), PW'(1)};
        for (int i = 0; i < 100 && got_q.size() < 4; i++) begin
            tick();
            if (bus.frame_strobe) begin
                got_q.push_back(bus.frame_pat);
                st_cyc.push_back(cyc);
                check("auto_frame", bus.frame, pat_frame(int'(bus.frame_pat)));
            end
        end
        check("auto_strobe_count", FW'(got_q.size()), FW'(4));
        for (int i = 0; i < got_q.size() && i < 4; i++) begin
            check("auto_pat_seq", FW'(got_q[i]), FW'(exp_q[i]));
            if (i > 0) check("auto_gap", FW'(st_cyc[i] - st_cyc[i-1]), FW'(HOLD_W'(4) + ROWS + 2));
        end
        bus.auto_en = 1'b0;

        // Random traffic against the model
        for (int i = 0; i < 2000; i++) begin
            bus.wr_en   = 1'($urandom_range(0, 1));
            bus.wr_pat  = PW'($urandom_range(0, 13));
            bus.wr_row  = RW'($urandom_range(0, 11));
            bus.wr_data = COLS'($urandom);
            bus.sel_load = ($urandom_range(0, 19) == 0);
            bus.sel_pat  = PW'($urandom_range(0, 15));
            if ($urandom_range(0, 49) == 0) bus.auto_en = ~bus.auto_en;
            if ($urandom_range(0, 29) == 0) bus.hold_cycles = HOLD_W'($urandom_range(0, 5));
            if ($urandom_range(0, 39) == 0) bus.last_pat = PW'($urandom_range(0, 15));
            tick();
        end
        bus.wr_en = 1'b0; bus.sel_load = 1'b0; bus.auto_en = 1'b0;
        repeat (ROWS + 2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
